// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types
//   Shared LC-3b datapath types used by the memory-side blocks.
//   lc3b_word      : 16-bit machine word / address
//   lc3b_mem_wmask : per-byte write mask for a 16-bit word
//   arb_state_t    : state encoding of the memory port arbiter FSM
// ---------------------------------------------------------------------------
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_I = 3'd1,
        SERVE_D = 3'd2,
        DONE_I  = 3'd3,
        DONE_D  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Responder for the core's split instruction/data memory interface.
//   Serializes ifetch reads and data reads/writes onto a single physical
//   memory port and returns a one-cycle resp pulse on the originating side.
//
//   Ports:
//     clk, reset            : clock, asynchronous active-high reset
//     ifetch_read/address   : instruction read request (level-held)
//     ifetch_resp/rdata     : one-cycle completion pulse + read data
//     mem_read/write        : data request (level-held); write wins if both
//     mem_address/wdata/
//     mem_byte_enable       : data request payload
//     mem_resp/rdata        : one-cycle completion pulse + read data
//     pmem_read/write       : physical strobes, held until pmem_resp
//     pmem_address/wdata/
//     pmem_byte_enable      : physical payload, driven from latched request
//     pmem_resp/rdata       : physical completion pulse + read data
//
//   Parameter DATA_PRIORITY: 1 -> data wins a tie with ifetch, 0 -> ifetch.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import lc3b_types::*;
#(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          ifetch_read,
    input  lc3b_word      ifetch_address,
    output logic          ifetch_resp,
    output lc3b_word      ifetch_rdata,

    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    input  lc3b_mem_wmask mem_byte_enable,
    output logic          mem_resp,
    output lc3b_word      mem_rdata,

    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_word      pmem_address,
    output lc3b_word      pmem_wdata,
    output lc3b_mem_wmask pmem_byte_enable,
    input  logic          pmem_resp,
    input  lc3b_word      pmem_rdata
);

    arb_state_t    state;
    lc3b_word      addr_q;
    lc3b_word      wdata_q;
    lc3b_mem_wmask be_q;
    logic          wr_q;
    lc3b_word      i_rdata_q;
    lc3b_word      d_rdata_q;

    logic d_req;
    logic take_d;
    logic take_i;

    // Arbitration is only meaningful in IDLE; the FSM ignores it elsewhere.
    assign d_req  = mem_read | mem_write;
    assign take_d = DATA_PRIORITY ? d_req : (d_req & ~ifetch_read);
    assign take_i = DATA_PRIORITY ? (ifetch_read & ~d_req) : ifetch_read;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            be_q      <= 2'b00;
            wr_q      <= 1'b0;
            i_rdata_q <= 16'h0000;
            d_rdata_q <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take_d) begin
                        state   <= SERVE_D;
                        addr_q  <= mem_address;
                        wdata_q <= mem_wdata;
                        be_q    <= mem_byte_enable;
                        // A simultaneous read+write collapses to the write.
                        wr_q    <= mem_write;
                    end else if (take_i) begin
                        state   <= SERVE_I;
                        addr_q  <= ifetch_address;
                        wr_q    <= 1'b0;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        i_rdata_q <= pmem_rdata;
                        state     <= DONE_I;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        if (!wr_q)
                            d_rdata_q <= pmem_rdata;
                        state <= DONE_D;
                    end
                end
                // DONE states never sample requests: the requester is still
                // holding its level this cycle and must not be re-served.
                DONE_I:  state <= IDLE;
                DONE_D:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode from state alone, so reset drops them immediately and
    // no CPU input can reach the physical port combinationally.
    assign pmem_read        = (state == SERVE_I) | ((state == SERVE_D) & ~wr_q);
    assign pmem_write       = (state == SERVE_D) & wr_q;
    assign pmem_address     = addr_q;
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = be_q;

    assign ifetch_resp  = (state == DONE_I);
    assign mem_resp     = (state == DONE_D);
    assign ifetch_rdata = i_rdata_q;
    assign mem_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifetch_read;
    logic [15:0] ifetch_address;
    logic        ifetch_resp;
    logic [15:0] ifetch_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic        pmem_resp;
    logic [15:0] pmem_rdata;

    int vectors = 0;
    int errors  = 0;

    // physical memory model controls
    int          pm_wait  = 0;
    int          wcnt     = 0;
    logic        addr_mode = 1'b0;
    logic [15:0] pm_data  = 16'h0000;

    // window statistics
    int          n_rd, n_wr, n_trans, n_iresp, n_mresp, at_iresp, at_mresp;
    logic [15:0] cap_addr, cap_wdata;
    logic [1:0]  cap_be;

    mem_port_arbiter #(.DATA_PRIORITY(1'b1)) dut (
        .clk(clk), .reset(reset),
        .ifetch_read(ifetch_read), .ifetch_address(ifetch_address),
        .ifetch_resp(ifetch_resp), .ifetch_rdata(ifetch_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_byte_enable(pmem_byte_enable),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    // Physical memory: answers after pm_wait extra strobe cycles.
    always @(negedge clk) begin
        if (reset) begin
            pmem_resp = 1'b0;
            wcnt      = 0;
        end else if (pmem_read || pmem_write) begin
            if (wcnt == pm_wait) begin
                pmem_resp = 1'b1;
                wcnt      = 0;
            end else begin
                pmem_resp = 1'b0;
                wcnt      = wcnt + 1;
            end
        end else begin
            pmem_resp = 1'b0;
            wcnt      = 0;
        end
        pmem_rdata = addr_mode ? (pmem_address + 16'h1000) : pm_data;
    end

    // Runs ncyc cycles from a negedge where requests were just applied;
    // drops each request hold cycles after its resp is seen.
    task automatic run_window(input int ncyc, input int hold);
        logic prev;
        int   idrop, mdrop;
        prev = 1'b0; idrop = -1; mdrop = -1;
        n_rd = 0; n_wr = 0; n_trans = 0; n_iresp = 0; n_mresp = 0;
        at_iresp = -1; at_mresp = -1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if ((pmem_read || pmem_write) && !prev) n_trans++;
            prev = pmem_read || pmem_write;
            if (pmem_read) n_rd++;
            if (pmem_write) begin
                n_wr++;
                cap_wdata = pmem_wdata;
                cap_be    = pmem_byte_enable;
            end
            if (pmem_read || pmem_write) cap_addr = pmem_address;
            if (ifetch_resp) begin n_iresp++; at_iresp = k; idrop = k + hold; end
            if (mem_resp)    begin n_mresp++; at_mresp = k; mdrop = k + hold; end
            if (k == idrop) ifetch_read = 1'b0;
            if (k == mdrop) begin mem_read = 1'b0; mem_write = 1'b0; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        ifetch_read = 0; ifetch_address = 0; mem_read = 0; mem_write = 0;
        mem_address = 0; mem_wdata = 0; mem_byte_enable = 0;
        repeat (2) @(negedge clk);
        vectors++; if ({pmem_read, pmem_write, ifetch_resp, mem_resp} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes got %b want 0000", {pmem_read, pmem_write, ifetch_resp, mem_resp}); end
        vectors++; if ({pmem_address, pmem_wdata, pmem_byte_enable} !== 34'h0) begin
            errors++; $display("FAIL reset_pmem_regs got %h want 0", {pmem_address, pmem_wdata, pmem_byte_enable}); end
        vectors++; if ({ifetch_rdata, mem_rdata} !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h want 0", {ifetch_rdata, mem_rdata}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lone_ifetch;
        pm_wait = 2; addr_mode = 1'b0; pm_data = 16'h1234;
        ifetch_address = 16'h0040; ifetch_read = 1'b1;
        run_window(8, 0);
        vectors++; if (n_rd !== 3) begin errors++; $display("FAIL ifetch_read_cycles got %0d want 3", n_rd); end
        vectors++; if (cap_addr !== 16'h0040) begin errors++; $display("FAIL ifetch_addr got %h want 0040", cap_addr); end
        vectors++; if (n_iresp !== 1 || at_iresp !== 4) begin
            errors++; $display("FAIL ifetch_resp got n=%0d at=%0d want n=1 at=4", n_iresp, at_iresp); end
        vectors++; if (ifetch_rdata !== 16'h1234) begin errors++; $display("FAIL ifetch_rdata got %h want 1234", ifetch_rdata); end
        vectors++; if (n_mresp !== 0 || mem_rdata !== 16'h0000) begin
            errors++; $display("FAIL ifetch_no_mem got n=%0d rdata=%h want 0/0000", n_mresp, mem_rdata); end
    endtask

    task automatic test_priority;
        pm_wait = 0; addr_mode = 1'b1;
        ifetch_address = 16'h0060; ifetch_read = 1'b1;
        mem_address = 16'h0100; mem_read = 1'b1;
        run_window(10, 0);
        vectors++; if (at_mresp !== 2 || n_mresp !== 1) begin
            errors++; $display("FAIL prio_mem_resp got n=%0d at=%0d want n=1 at=2", n_mresp, at_mresp); end
        vectors++; if (at_iresp !== 5 || n_iresp !== 1) begin
            errors++; $display("FAIL prio_ifetch_resp got n=%0d at=%0d want n=1 at=5", n_iresp, at_iresp); end
        vectors++; if (mem_rdata !== 16'h1100) begin errors++; $display("FAIL prio_mem_rdata got %h want 1100", mem_rdata); end
        vectors++; if (ifetch_rdata !== 16'h1060) begin errors++; $display("FAIL prio_ifetch_rdata got %h want 1060", ifetch_rdata); end
        vectors++; if (n_rd !== 2 || n_trans !== 2) begin
            errors++; $display("FAIL prio_pmem got rd=%0d tr=%0d want 2/2", n_rd, n_trans); end
    endtask

    task automatic test_write;
        pm_wait = 1; addr_mode = 1'b1;
        mem_address = 16'h0200; mem_wdata = 16'hBEEF; mem_byte_enable = 2'b01; mem_write = 1'b1;
        run_window(8, 0);
        vectors++; if (n_wr !== 2 || n_rd !== 0) begin
            errors++; $display("FAIL write_strobes got wr=%0d rd=%0d want 2/0", n_wr, n_rd); end
        vectors++; if ({cap_addr, cap_wdata, cap_be} !== {16'h0200, 16'hBEEF, 2'b01}) begin
            errors++; $display("FAIL write_payload got %h/%h/%b want 0200/beef/01", cap_addr, cap_wdata, cap_be); end
        vectors++; if (n_mresp !== 1 || at_mresp !== 3) begin
            errors++; $display("FAIL write_resp got n=%0d at=%0d want 1/3", n_mresp, at_mresp); end
        vectors++; if (mem_rdata !== 16'h1100 || ifetch_rdata !== 16'h1060) begin
            errors++; $display("FAIL write_rdata_hold got %h/%h want 1100/1060", mem_rdata, ifetch_rdata); end
    endtask

    task automatic test_held_through_done;
        pm_wait = 0; addr_mode = 1'b1;
        mem_address = 16'h0300; mem_read = 1'b1;
        run_window(8, 1);
        vectors++; if (n_trans !== 1 || n_mresp !== 1) begin
            errors++; $display("FAIL held_single got trans=%0d resp=%0d want 1/1", n_trans, n_mresp); end
        vectors++; if (mem_rdata !== 16'h1300) begin errors++; $display("FAIL held_rdata got %h want 1300", mem_rdata); end
    endtask

    task automatic test_read_write_both;
        pm_wait = 0; addr_mode = 1'b1;
        mem_address = 16'h0400; mem_wdata = 16'h1111; mem_byte_enable = 2'b11;
        mem_read = 1'b1; mem_write = 1'b1;
        run_window(8, 0);
        vectors++; if (n_wr !== 1 || n_rd !== 0 || n_mresp !== 1) begin
            errors++; $display("FAIL both_write got wr=%0d rd=%0d resp=%0d want 1/0/1", n_wr, n_rd, n_mresp); end
        vectors++; if (mem_rdata !== 16'h1300) begin errors++; $display("FAIL both_rdata_hold got %h want 1300", mem_rdata); end
    endtask

    task automatic test_reset_mid;
        pm_wait = 5; addr_mode = 1'b1;
        mem_address = 16'h0500; mem_read = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL abort_pre got %b want 1", pmem_read); end
        reset = 1'b1;
        #1;
        vectors++; if ({pmem_read, pmem_write, mem_resp} !== 3'b000) begin
            errors++; $display("FAIL abort_async got %b want 000", {pmem_read, pmem_write, mem_resp}); end
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_window(6, 0);
        vectors++; if (n_mresp !== 0 || n_trans !== 0) begin
            errors++; $display("FAIL abort_quiet got resp=%0d trans=%0d want 0/0", n_mresp, n_trans); end
        pm_wait = 0;
        ifetch_address = 16'h0050; ifetch_read = 1'b1;
        run_window(6, 0);
        vectors++; if (n_iresp !== 1 || at_iresp !== 2 || ifetch_rdata !== 16'h1050) begin
            errors++; $display("FAIL abort_recover got n=%0d at=%0d rdata=%h want 1/2/1050", n_iresp, at_iresp, ifetch_rdata); end
    endtask

    initial begin
        test_reset;
        test_lone_ifetch;
        test_priority;
        test_write;
        test_held_through_done;
        test_read_write_both;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
